// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and message ROM for the character-LCD demo driver.
// Command bytes and the fixed line-1 text live here so the sequencer stays table-free.
package lcd_pkg;

   localparam int CNT_W = 20;
   localparam int WR_CNT_W = 16;

   localparam logic [7:0] LCD_FUNC_SET = 8'h28;
   localparam logic [7:0] LCD_ENTRY    = 8'h06;
   localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
   localparam logic [7:0] LCD_CLEAR    = 8'h01;
   localparam logic [7:0] LCD_ADDR0    = 8'h80;

   typedef enum logic [3:0] {
      S_PWRUP, S_INIT1, S_INIT2, S_INIT3, S_INIT4, S_CFG, S_ADDR, S_TEXT, S_DONE
   } state_t;

   typedef enum logic [2:0] {
      PH_WAIT, PH_ISSUE_HI, PH_BUSY_HI, PH_GAP, PH_ISSUE_LO, PH_BUSY_LO, PH_IDLE
   } phase_t;

   typedef enum logic [1:0] {
      W_IDLE, W_SETUP, W_HIGH, W_HOLD
   } wr_state_t;

   function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return LCD_FUNC_SET;
         2'd1:    return LCD_ENTRY;
         2'd2:    return LCD_DISP_ON;
         default: return LCD_CLEAR;
      endcase
   endfunction

   // "FPGA LCD TEST OK"
   function automatic logic [7:0] msg_char(input logic [3:0] idx);
      case (idx)
         4'd0:    return 8'h46;
         4'd1:    return 8'h50;
         4'd2:    return 8'h47;
         4'd3:    return 8'h41;
         4'd4:    return 8'h20;
         4'd5:    return 8'h4C;
         4'd6:    return 8'h43;
         4'd7:    return 8'h44;
         4'd8:    return 8'h20;
         4'd9:    return 8'h54;
         4'd10:   return 8'h45;
         4'd11:   return 8'h53;
         4'd12:   return 8'h54;
         4'd13:   return 8'h20;
         4'd14:   return 8'h4F;
         default: return 8'h4B;
      endcase
   endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Single 4-bit LCD write: setup T_SU, E high T_EH, hold T_SU; done pulses in the last hold cycle.
// start is accepted only while idle; rs/data are latched at start and held until the next start.
module lcd_nibble_writer
   import lcd_pkg::*;
#(
   parameter int T_EH = 12,
   parameter int T_SU = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       rs_sel,
   input  logic [3:0] nibble,
   output logic       busy,
   output logic       done,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic [3:0] lcd_data
);

   wr_state_t           wst, wst_n;
   logic [WR_CNT_W-1:0] cnt, cnt_n;
   logic                rs_r;
   logic [3:0]          data_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wst    <= W_IDLE;
         cnt    <= '0;
         rs_r   <= 1'b0;
         data_r <= 4'h0;
      end else begin
         wst <= wst_n;
         cnt <= cnt_n;
         if (start && wst == W_IDLE) begin
            rs_r   <= rs_sel;
            data_r <= nibble;
         end
      end
   end

   always_comb begin
      wst_n = wst;
      cnt_n = cnt;
      done  = 1'b0;
      case (wst)
         W_IDLE: begin
            cnt_n = '0;
            if (start) wst_n = W_SETUP;
         end
         W_SETUP: begin
            if (cnt == WR_CNT_W'(T_SU - 1)) begin
               cnt_n = '0;
               wst_n = W_HIGH;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         W_HIGH: begin
            if (cnt == WR_CNT_W'(T_EH - 1)) begin
               cnt_n = '0;
               wst_n = W_HOLD;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         W_HOLD: begin
            if (cnt == WR_CNT_W'(T_SU - 1)) begin
               cnt_n = '0;
               wst_n = W_IDLE;
               done  = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: wst_n = W_IDLE;
      endcase
   end

   // E decoded straight from state so an async reset drops it at once
   assign lcd_e    = (wst == W_HIGH);
   assign busy     = (wst != W_IDLE);
   assign lcd_rs   = rs_r;
   assign lcd_data = data_r;

endmodule

// File: rtl/lcd_test_display.sv
// Self-running HD44780 4-bit driver: power-on init, 4-bit/2-line config, clear, then "FPGA LCD TEST OK".
// Sequencer walks states/phases; every nibble goes through lcd_nibble_writer, then terminal idle.
module lcd_test_display
   import lcd_pkg::*;
#(
   parameter int T_PWRUP = 750000,
   parameter int T_4MS   = 205000,
   parameter int T_100US = 5000,
   parameter int T_40US  = 2000,
   parameter int T_CLR   = 82000,
   parameter int T_EH    = 12,
   parameter int T_SU    = 2,
   parameter int T_NIB   = 50
) (
   input  logic clk,
   input  logic rst_n,
   output logic sf_e,
   output logic e,
   output logic rs,
   output logic rw,
   output logic d,
   output logic c,
   output logic b,
   output logic a
);

   state_t           state, state_n;
   phase_t           phase, phase_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [1:0]       cfg_idx, cfg_n;
   logic [3:0]       char_idx, char_n;

   logic             wr_start, wr_busy, wr_done;
   logic [3:0]       wr_nibble;
   logic [7:0]       cur_byte;
   logic [CNT_W-1:0] wait_lim;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_PWRUP;
         phase    <= PH_WAIT;
         cnt      <= '0;
         cfg_idx  <= '0;
         char_idx <= '0;
      end else begin
         state    <= state_n;
         phase    <= phase_n;
         cnt      <= cnt_n;
         cfg_idx  <= cfg_n;
         char_idx <= char_n;
      end
   end

   always_comb begin
      cur_byte = LCD_ADDR0;
      case (state)
         S_CFG:   cur_byte = cfg_byte(cfg_idx);
         S_TEXT:  cur_byte = msg_char(char_idx);
         default: cur_byte = LCD_ADDR0;
      endcase
   end

   always_comb begin
      wait_lim = CNT_W'(T_40US);
      case (state)
         S_PWRUP: wait_lim = CNT_W'(T_PWRUP);
         S_INIT1: wait_lim = CNT_W'(T_4MS);
         S_INIT2: wait_lim = CNT_W'(T_100US);
         S_CFG:   wait_lim = (cur_byte == LCD_CLEAR) ? CNT_W'(T_CLR) : CNT_W'(T_40US);
         default: wait_lim = CNT_W'(T_40US);
      endcase
   end

   // Init states send a lone nibble through the LO path
   always_comb begin
      wr_nibble = cur_byte[3:0];
      if (state == S_INIT1 || state == S_INIT2 || state == S_INIT3)
         wr_nibble = 4'h3;
      else if (state == S_INIT4)
         wr_nibble = 4'h2;
      else if (phase == PH_ISSUE_HI)
         wr_nibble = cur_byte[7:4];
   end

   always_comb begin
      state_n  = state;
      phase_n  = phase;
      cnt_n    = cnt;
      cfg_n    = cfg_idx;
      char_n   = char_idx;
      wr_start = 1'b0;
      case (phase)
         PH_WAIT: begin
            if (cnt == wait_lim - 1'b1) begin
               cnt_n   = '0;
               phase_n = PH_ISSUE_HI;
               case (state)
                  S_PWRUP: begin state_n = S_INIT1; phase_n = PH_ISSUE_LO; end
                  S_INIT1: begin state_n = S_INIT2; phase_n = PH_ISSUE_LO; end
                  S_INIT2: begin state_n = S_INIT3; phase_n = PH_ISSUE_LO; end
                  S_INIT3: begin state_n = S_INIT4; phase_n = PH_ISSUE_LO; end
                  S_INIT4: begin state_n = S_CFG; cfg_n = '0; end
                  S_CFG: begin
                     if (cfg_idx == 2'd3) state_n = S_ADDR;
                     else                 cfg_n   = cfg_idx + 1'b1;
                  end
                  S_ADDR: begin state_n = S_TEXT; char_n = '0; end
                  S_TEXT: begin
                     if (char_idx == 4'd15) begin
                        state_n = S_DONE;
                        phase_n = PH_IDLE;
                     end else begin
                        char_n = char_idx + 1'b1;
                     end
                  end
                  default: begin state_n = S_DONE; phase_n = PH_IDLE; end
               endcase
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         PH_ISSUE_HI: begin
            if (!wr_busy) begin
               wr_start = 1'b1;
               phase_n  = PH_BUSY_HI;
            end
         end
         PH_BUSY_HI: if (wr_done) phase_n = PH_GAP;
         PH_GAP: begin
            if (cnt == CNT_W'(T_NIB - 1)) begin
               cnt_n   = '0;
               phase_n = PH_ISSUE_LO;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         PH_ISSUE_LO: begin
            if (!wr_busy) begin
               wr_start = 1'b1;
               phase_n  = PH_BUSY_LO;
            end
         end
         PH_BUSY_LO: if (wr_done) phase_n = PH_WAIT;
         default: phase_n = PH_IDLE;
      endcase
   end

   lcd_nibble_writer #(
      .T_EH (T_EH),
      .T_SU (T_SU)
   ) u_writer (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (wr_start),
      .rs_sel   (state == S_TEXT),
      .nibble   (wr_nibble),
      .busy     (wr_busy),
      .done     (wr_done),
      .lcd_e    (e),
      .lcd_rs   (rs),
      .lcd_data ({d, c, b, a})
   );

   assign sf_e = 1'b1;
   assign rw   = 1'b0;

endmodule

// File: tb/tb_lcd_test_display.sv
// Directed bench for lcd_test_display with shortened timing; a negedge monitor logs every E pulse.
module tb_lcd_test_display;

   localparam int P_PWRUP = 100, P_4MS = 40, P_100US = 20, P_40US = 10, P_CLR = 30;
   localparam int P_EH = 3, P_SU = 1, P_NIB = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sf_e, e, rs, rw, d, c, b, a;

   lcd_test_display #(
      .T_PWRUP (P_PWRUP), .T_4MS (P_4MS), .T_100US (P_100US), .T_40US (P_40US),
      .T_CLR (P_CLR), .T_EH (P_EH), .T_SU (P_SU), .T_NIB (P_NIB)
   ) dut (
      .clk (clk), .rst_n (rst_n), .sf_e (sf_e), .e (e), .rs (rs), .rw (rw),
      .d (d), .c (c), .b (b), .a (a)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // pulse log
   int         rise_cyc[$];
   logic [3:0] nib_q[$];
   logic       rs_q[$];
   int         width_q[$];
   int         bad_const = 0;
   int         unstable = 0;
   logic       e_q = 1'b0;
   int         hi_cnt = 0;
   logic [3:0] nib_l;
   logic       rs_l;

   always @(negedge clk) begin
      if (rw !== 1'b0 || sf_e !== 1'b1) bad_const++;
      if (e === 1'b1 && e_q !== 1'b1) begin
         rise_cyc.push_back(cyc);
         nib_q.push_back({d, c, b, a});
         rs_q.push_back(rs);
         nib_l  = {d, c, b, a};
         rs_l   = rs;
         hi_cnt = 1;
      end else if (e === 1'b1) begin
         hi_cnt++;
         if ({d, c, b, a} !== nib_l || rs !== rs_l) unstable++;
      end else if (e_q === 1'b1) begin
         width_q.push_back(hi_cnt);
      end
      e_q = e;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_ge(input string tag, input int obs, input int min);
      tests++;
      assert (obs >= min) else begin
         fails++;
         $error("FAIL %s: observed %0d expected >= %0d", tag, obs, min);
      end
   endtask

   task automatic wait_pulses(input int n, input int budget, input string tag);
      int k = 0;
      while (rise_cyc.size() < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      chk(tag, (rise_cyc.size() >= n) ? 1 : 0, 1);
   endtask

   task automatic clear_log();
      rise_cyc.delete();
      nib_q.delete();
      rs_q.delete();
      width_q.delete();
   endtask

   // init nibbles then config/address byte nibbles, all rs=0
   function automatic logic [3:0] exp_cmd_nib(input int i);
      logic [3:0] tbl [14];
      tbl = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1, 4'h8, 4'h0};
      return tbl[i];
   endfunction

   task automatic check_sequence(input string pfx, input int rel_cyc);
      string msg;
      msg = "FPGA LCD TEST OK";
      chk_ge({pfx, "_pwrup_quiet"}, rise_cyc[0] - rel_cyc, P_PWRUP);
      for (int i = 0; i < 14; i++) begin
         chk({pfx, "_cmd_nib"}, int'(nib_q[i]), int'(exp_cmd_nib(i)));
         chk({pfx, "_cmd_rs"}, int'(rs_q[i]), 0);
      end
      chk_ge({pfx, "_gap_4ms"},   rise_cyc[1] - rise_cyc[0], P_4MS + P_EH + 2 * P_SU);
      chk_ge({pfx, "_gap_100us"}, rise_cyc[2] - rise_cyc[1], P_100US + P_EH + 2 * P_SU);
      chk_ge({pfx, "_gap_init3"}, rise_cyc[3] - rise_cyc[2], P_40US + P_EH + 2 * P_SU);
      chk_ge({pfx, "_gap_init4"}, rise_cyc[4] - rise_cyc[3], P_40US + P_EH + 2 * P_SU);
      chk_ge({pfx, "_gap_nib"},   rise_cyc[5] - rise_cyc[4], P_NIB + P_EH + 2 * P_SU);
      chk_ge({pfx, "_gap_clear"}, rise_cyc[12] - rise_cyc[11], P_CLR + P_EH + 2 * P_SU);
      for (int k = 0; k < 16; k++) begin
         chk({pfx, "_char"}, int'({nib_q[14 + 2 * k], nib_q[15 + 2 * k]}), int'(msg[k]));
         chk({pfx, "_char_rs"}, int'(rs_q[14 + 2 * k] & rs_q[15 + 2 * k]), 1);
      end
      for (int i = 0; i < 46; i++) chk({pfx, "_e_width"}, width_q[i], P_EH);
   endtask

   int rel_cyc;
   int n_before;

   initial begin
      repeat (4) @(posedge clk);
      #1;
      chk("rst_e", int'(e), 0);
      chk("rst_rs", int'(rs), 0);
      chk("rst_rw", int'(rw), 0);
      chk("rst_sf_e", int'(sf_e), 1);
      chk("rst_dcba", int'({d, c, b, a}), 0);

      // first full run
      rst_n   = 1'b1;
      rel_cyc = cyc;
      wait_pulses(46, 5000, "run1_complete");
      repeat (P_40US + 5) @(posedge clk);
      check_sequence("run1", rel_cyc);
      chk("stable_during_e", unstable, 0);

      n_before = rise_cyc.size();
      repeat (10000) @(posedge clk);
      #1;
      chk("done_no_pulses", rise_cyc.size(), n_before);
      chk("done_e_low", int'(e), 0);

      // reset in the middle of the 6th character's upper-nibble strobe
      clear_log();
      rst_n = 1'b0;
      #1;
      @(posedge clk);
      rst_n   = 1'b1;
      rel_cyc = cyc;
      wait_pulses(25, 5000, "run2_reach_char6");
      #1;
      chk("mid_strobe_e_high", int'(e), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_e_drop", int'(e), 0);
      chk("mid_reset_rs", int'(rs), 0);
      repeat (3) @(posedge clk);
      clear_log();
      #1;
      rst_n   = 1'b1;
      rel_cyc = cyc;
      wait_pulses(46, 5000, "run3_complete");
      repeat (P_40US + 5) @(posedge clk);
      check_sequence("run3", rel_cyc);
      chk("stable_total", unstable, 0);
      chk("rw_sf_e_const", bad_const, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
